// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined PCPU control with hazard/forwarding/halt; PIPE_CTRL_FWD_EN enables EX forwarding
module pipe_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int RA_IDX = 31
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       id_instr,
  input  logic              id_valid,
  input  logic              ex_redirect,
  input  logic              ext_stall,
  output logic [3:0]        id_npc_op,
  output logic [13:0]       ex_ctrl,
  output logic [5:0]        mem_ctrl,
  output logic [3:0]        wb_ctrl,
  output logic [REG_AW-1:0] wb_dest,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              pc_hold,
  output logic              flush_ifid,
  output logic              halt
);
  localparam logic [3:0] NPC_PLUS4 = 4'd0, NPC_BEQ = 4'd1, NPC_BLTZ = 4'd5, NPC_BGEZ = 4'd6,
                         NPC_JUMP = 4'd7, NPC_JR = 4'd8, NPC_NOP = 4'd15;
  localparam logic [5:0] ALU_NOP = 6'd0, ALU_ADD = 6'd1, ALU_SUB = 6'd2, ALU_AND = 6'd3, ALU_OR = 6'd4,
                         ALU_XOR = 6'd5, ALU_NOR = 6'd6, ALU_SLT = 6'd7, ALU_SLTU = 6'd8, ALU_SLL = 6'd9,
                         ALU_SRL = 6'd10, ALU_SRA = 6'd11, ALU_SLLV = 6'd12, ALU_SRLV = 6'd13,
                         ALU_SRAV = 6'd14, ALU_LUI = 6'd15, ALU_ADDU = 6'd16, ALU_SUBU = 6'd17;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1;
  localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
  localparam logic [1:0] DMWR_NOP = 2'd0, DMWR_SB = 2'd1, DMWR_SH = 2'd2, DMWR_SW = 2'd3;
  localparam logic [2:0] DMRE_NOP = 3'd0, DMRE_LB = 3'd1, DMRE_LBU = 3'd2, DMRE_LH = 3'd3,
                         DMRE_LHU = 3'd4, DMRE_LW = 3'd5;
  localparam logic [1:0] TO_ALU = 2'd0, TO_DM = 2'd1, TO_PC = 2'd2;

  typedef struct packed {
    logic [5:0]        aluop;
    logic              alusrc;
    logic              alusrc0;
    logic [1:0]        extop;
    logic              npcregrs;
    logic [1:0]        regdst;
    logic [1:0]        dmwr;
    logic [2:0]        dmre;
    logic [1:0]        toreg;
    logic              rfwr;
    logic              illegal;
    logic [REG_AW-1:0] dest;
`ifdef PIPE_CTRL_FWD_EN
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
`endif
    logic              valid;
  } ex_t;

  typedef struct packed {
    logic [1:0]        dmwr;
    logic [2:0]        dmre;
    logic [1:0]        toreg;
    logic              rfwr;
    logic              illegal;
    logic [REG_AW-1:0] dest;
    logic              valid;
  } mem_t;

  typedef struct packed {
    logic [1:0]        toreg;
    logic              rfwr;
    logic              illegal;
    logic [REG_AW-1:0] dest;
    logic              valid;
  } wb_t;

  logic [5:0]        op, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              shamt_shift, use_rs, use_rt, hazard, ex_wr, mem_wr;
  logic [3:0]        npc;
  ex_t               id_d, ex, ex_n;
  mem_t              mem, mem_n;
  wb_t               wb, wb_n;
  logic              unused_shamt;

  assign op           = id_instr[31:26];
  assign funct        = id_instr[5:0];
  assign rs           = id_instr[21 +: REG_AW];
  assign rt           = id_instr[16 +: REG_AW];
  assign rd           = id_instr[11 +: REG_AW];
  assign unused_shamt = ^id_instr[10:6];
  assign shamt_shift  = op == 6'h00 && funct[5:2] == 4'd0 && funct[1:0] != 2'b01;
  assign use_rs       = id_valid && !(op == 6'h02 || op == 6'h03 || op == 6'h0F || shamt_shift);
  assign use_rt       = id_valid && (op == 6'h00 || op == 6'h04 || op == 6'h05 ||
                                     op == 6'h28 || op == 6'h29 || op == 6'h2B);

  always_comb begin
    id_d       = '0;
    id_d.valid = 1'b1;
    npc        = NPC_PLUS4;
    case (op)
      6'h00: begin
        id_d.regdst  = RD_RD;
        id_d.rfwr    = 1'b1;
        id_d.alusrc0 = shamt_shift;
        case (funct)
          6'h00: id_d.aluop = ALU_SLL;
          6'h02: id_d.aluop = ALU_SRL;
          6'h03: id_d.aluop = ALU_SRA;
          6'h04: id_d.aluop = ALU_SLLV;
          6'h06: id_d.aluop = ALU_SRLV;
          6'h07: id_d.aluop = ALU_SRAV;
          6'h08: begin npc = NPC_JR; id_d.npcregrs = 1'b1; id_d.rfwr = 1'b0; end
          6'h09: begin npc = NPC_JR; id_d.npcregrs = 1'b1; id_d.regdst = RD_RA; id_d.toreg = TO_PC; end
          6'h20: id_d.aluop = ALU_ADD;
          6'h21: id_d.aluop = ALU_ADDU;
          6'h22: id_d.aluop = ALU_SUB;
          6'h23: id_d.aluop = ALU_SUBU;
          6'h24: id_d.aluop = ALU_AND;
          6'h25: id_d.aluop = ALU_OR;
          6'h26: id_d.aluop = ALU_XOR;
          6'h27: id_d.aluop = ALU_NOR;
          6'h2A: id_d.aluop = ALU_SLT;
          6'h2B: id_d.aluop = ALU_SLTU;
          default: id_d.rfwr = 1'b0;
        endcase
      end
      6'h01: begin
        npc         = id_instr[20:16] == 5'd0 ? NPC_BLTZ : NPC_BGEZ;
        id_d.aluop  = ALU_SUB;
        id_d.extop  = EXT_SIGN;
      end
      6'h02: npc = NPC_JUMP;
      6'h03: begin npc = NPC_JUMP; id_d.regdst = RD_RA; id_d.toreg = TO_PC; id_d.rfwr = 1'b1; end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        npc        = NPC_BEQ + {2'b00, op[1:0]};
        id_d.aluop = ALU_SUB;
        id_d.extop = EXT_SIGN;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        id_d.alusrc = 1'b1;
        id_d.rfwr   = 1'b1;
        id_d.extop  = op[2] ? EXT_ZERO : EXT_SIGN;
        case (op[2:0])
          3'd0: id_d.aluop = ALU_ADD;
          3'd1: id_d.aluop = ALU_ADDU;
          3'd2: id_d.aluop = ALU_SLT;
          3'd3: id_d.aluop = ALU_SLTU;
          3'd4: id_d.aluop = ALU_AND;
          3'd5: id_d.aluop = ALU_OR;
          3'd6: id_d.aluop = ALU_XOR;
          default: id_d.aluop = ALU_LUI;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        id_d.aluop  = ALU_ADD;
        id_d.alusrc = 1'b1;
        id_d.extop  = EXT_SIGN;
        id_d.toreg  = TO_DM;
        id_d.rfwr   = 1'b1;
        id_d.dmre   = op[2:0] == 3'd0 ? DMRE_LB : op[2:0] == 3'd1 ? DMRE_LH :
                      op[2:0] == 3'd3 ? DMRE_LW : op[2:0] == 3'd4 ? DMRE_LBU : DMRE_LHU;
      end
      6'h28, 6'h29, 6'h2B: begin
        id_d.aluop  = ALU_ADD;
        id_d.alusrc = 1'b1;
        id_d.extop  = EXT_SIGN;
        id_d.dmwr   = op[1:0] == 2'd0 ? DMWR_SB : op[1:0] == 2'd1 ? DMWR_SH : DMWR_SW;
      end
      default: begin npc = NPC_NOP; id_d.illegal = 1'b1; end
    endcase
    id_d.dest = id_d.regdst == RD_RD ? rd : id_d.regdst == RD_RA ? REG_AW'(RA_IDX) : rt;
`ifdef PIPE_CTRL_FWD_EN
    id_d.rs = rs;
    id_d.rt = rt;
`endif
  end

  assign ex_wr  = ex.valid && ex.rfwr && ex.dest != '0;
  assign mem_wr = mem.valid && mem.rfwr && mem.dest != '0;

`ifdef PIPE_CTRL_FWD_EN
  logic wb_wr;
  assign wb_wr  = wb.valid && wb.rfwr && wb.dest != '0;
  assign hazard = ex_wr && ex.dmre != DMRE_NOP &&
                  ((use_rs && rs == ex.dest) || (use_rt && rt == ex.dest));
  assign fwd_a  = mem_wr && mem.dest == ex.rs ? 2'b10 : wb_wr && wb.dest == ex.rs ? 2'b01 : 2'b00;
  assign fwd_b  = mem_wr && mem.dest == ex.rt ? 2'b10 : wb_wr && wb.dest == ex.rt ? 2'b01 : 2'b00;
`else
  // Without forwarding the regfile's write-first bypass covers WB, so only EX/MEM writers stall ID
  assign hazard = (use_rs && ((ex_wr && rs == ex.dest) || (mem_wr && rs == mem.dest))) ||
                  (use_rt && ((ex_wr && rt == ex.dest) || (mem_wr && rt == mem.dest)));
  assign fwd_a  = 2'b00;
  assign fwd_b  = 2'b00;
`endif

  always_comb begin
    ex_n  = halt || ex_redirect || hazard || !id_valid ? '0 : id_d;
    mem_n = halt ? '0 : {ex.dmwr, ex.dmre, ex.toreg, ex.rfwr, ex.illegal, ex.dest, ex.valid};
    wb_n  = halt ? '0 : {mem.toreg, mem.rfwr, mem.illegal, mem.dest, mem.valid};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (!ext_stall) begin
      ex  <= ex_n;
      mem <= mem_n;
      wb  <= wb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) halt <= 1'b0;
    else halt <= halt || (wb.valid && wb.illegal);
  end

  assign id_npc_op  = id_valid ? npc : NPC_PLUS4;
  assign ex_ctrl    = {ex.aluop, ex.alusrc, ex.alusrc0, ex.extop, ex.npcregrs, ex.regdst, ex.valid};
  assign mem_ctrl   = {mem.dmwr, mem.dmre, mem.valid};
  assign wb_ctrl    = {wb.toreg, wb.rfwr && wb.valid, wb.valid};
  assign wb_dest    = wb.dest;
  assign pc_hold    = ext_stall || halt || (hazard && !ex_redirect);
  assign flush_ifid = ex_redirect && !ext_stall;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed scoreboard bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;
  logic        clk = 0, rstn = 0, id_valid = 0, ex_redirect = 0, ext_stall = 0;
  logic [31:0] id_instr = 0;
  logic [3:0]  id_npc_op, wb_ctrl;
  logic [13:0] ex_ctrl;
  logic [5:0]  mem_ctrl;
  logic [4:0]  wb_dest;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_hold, flush_ifid, halt;
  logic        adv = 0;
  int          checks = 0, errors = 0;
  logic [17:0] exq[$];
  logic [5:0]  memq[$];
  logic [8:0]  wbq[$];

  localparam logic [3:0]  NPC_PLUS4 = 4'd0, NPC_BLTZ = 4'd5, NPC_BGEZ = 4'd6, NPC_JUMP = 4'd7, NPC_NOP = 4'd15;
  localparam logic [13:0] EX_IMM = {6'd1, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b1};
  localparam logic [13:0] EX_ADD = {6'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1};
  localparam logic [13:0] EX_SUB = {6'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1};
  localparam logic [13:0] EX_JAL = {6'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1};
  localparam logic [13:0] EX_BR  = {6'd2, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 1'b1};
  localparam logic [13:0] EX_ILL = 14'd1;
  localparam logic [5:0]  MEM_LW = {2'd0, 3'd5, 1'b1}, MEM_SW = {2'd3, 3'd0, 1'b1}, MEM_ALU = 6'd1;
  localparam logic [3:0]  WB_ALU = {2'd0, 1'b1, 1'b1}, WB_LW = {2'd1, 1'b1, 1'b1};
  localparam logic [3:0]  WB_JAL = {2'd2, 1'b1, 1'b1}, WB_NW = {2'd0, 1'b0, 1'b1};
  localparam logic [31:0] LW8 = 32'h8C08_0000, ADD988 = 32'h0108_4820, ADDI1 = 32'h2001_0005;
  localparam logic [31:0] SUB211 = 32'h0021_1022, ADDI0 = 32'h2000_0007, ADD300 = 32'h0000_1820;
  localparam logic [31:0] SW9 = 32'hAC09_0004, JAL = 32'h0C00_0010, BGEZ = 32'h0401_0004;
  localparam logic [31:0] BLTZ = 32'h0400_0004, ILL = 32'hFC00_0000;
`ifdef PIPE_CTRL_FWD_EN
  localparam int LU_STALL = 1, RAW_STALL = 0;
  localparam logic [1:0] FWD_WB = 2'b01, FWD_MEM = 2'b10;
`else
  localparam int LU_STALL = 2, RAW_STALL = 2;
  localparam logic [1:0] FWD_WB = 2'b00, FWD_MEM = 2'b00;
`endif

  pipe_ctrl_unit dut (
    .clk(clk), .rstn(rstn), .id_instr(id_instr), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .ext_stall(ext_stall), .id_npc_op(id_npc_op), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
    .wb_ctrl(wb_ctrl), .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_hold(pc_hold),
    .flush_ifid(flush_ifid), .halt(halt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) adv <= !ext_stall;

  always @(negedge clk) if (adv) begin
    if (ex_ctrl[0]) begin
      if (exq.size() == 0) chk("ex_extra", {ex_ctrl, fwd_a, fwd_b}, 0);
      else chk("ex_stage", {ex_ctrl, fwd_a, fwd_b}, exq.pop_front());
    end
    if (mem_ctrl[0]) begin
      if (memq.size() == 0) chk("mem_extra", mem_ctrl, 0);
      else chk("mem_stage", mem_ctrl, memq.pop_front());
    end
    if (wb_ctrl[0]) begin
      if (wbq.size() == 0) chk("wb_extra", {wb_ctrl, wb_dest}, 0);
      else chk("wb_stage", {wb_ctrl, wb_dest}, wbq.pop_front());
    end
  end

  task automatic issue(input logic [31:0] ins, input int stalls, input logic [3:0] npc,
                       input logic [13:0] ex, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [5:0] mem, input logic [3:0] wb, input logic [4:0] dest);
    id_instr = ins;
    id_valid = 1;
    for (int i = 0; i < stalls; i++) begin
      #1 chk("stall", pc_hold, 1);
      @(negedge clk);
    end
    #1 chk("no_stall", pc_hold, 0);
    chk("npc_op", id_npc_op, npc);
    exq.push_back({ex, fa, fb});
    memq.push_back(mem);
    wbq.push_back({wb, dest});
    @(negedge clk);
    id_valid = 0;
  endtask

  task automatic idle(input int n);
    id_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ex", ex_ctrl, 0);
    chk("rst_mem", mem_ctrl, 0);
    chk("rst_wb", {wb_ctrl, wb_dest}, 0);
    chk("rst_comb", {pc_hold, flush_ifid, halt, fwd_a, fwd_b}, 0);
    chk("rst_npc", id_npc_op, NPC_PLUS4);
    rstn = 1;
    idle(1);
    issue(LW8, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_LW, WB_LW, 5'd8);
    issue(ADD988, LU_STALL, NPC_PLUS4, EX_ADD, FWD_WB, FWD_WB, MEM_ALU, WB_ALU, 5'd9);
    idle(4);
    issue(ADDI1, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_ALU, WB_ALU, 5'd1);
    issue(SUB211, RAW_STALL, NPC_PLUS4, EX_SUB, FWD_MEM, FWD_MEM, MEM_ALU, WB_ALU, 5'd2);
    idle(4);
    issue(ADDI0, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_ALU, WB_ALU, 5'd0);
    issue(ADD300, 0, NPC_PLUS4, EX_ADD, 2'b00, 2'b00, MEM_ALU, WB_ALU, 5'd3);
    issue(JAL, 0, NPC_JUMP, EX_JAL, 2'b00, 2'b00, MEM_ALU, WB_JAL, 5'd31);
    issue(BGEZ, 0, NPC_BGEZ, EX_BR, 2'b00, 2'b00, MEM_ALU, WB_NW, 5'd1);
    issue(BLTZ, 0, NPC_BLTZ, EX_BR, 2'b00, 2'b00, MEM_ALU, WB_NW, 5'd0);
    id_instr = BGEZ;
    #1 chk("bubble_npc", id_npc_op, NPC_PLUS4);
    idle(4);
    issue(LW8, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_LW, WB_LW, 5'd8);
    id_instr = ADD988;
    id_valid = 1;
    ex_redirect = 1;
    #1 chk("redir_flush", flush_ifid, 1);
    chk("redir_hold", pc_hold, 0);
    @(negedge clk);
    ex_redirect = 0;
    id_valid = 0;
    chk("redir_bubble", ex_ctrl[0], 0);
    idle(4);
    issue(SW9, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_SW, WB_NW, 5'd9);
    issue(LW8, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_LW, WB_LW, 5'd8);
    #1 rstn = 0;
    exq.delete();
    memq.delete();
    wbq.delete();
    @(negedge clk);
    chk("mrst_valid", {ex_ctrl[0], mem_ctrl[0], wb_ctrl[0]}, 0);
    chk("mrst_dmwr", mem_ctrl[5:4], 0);
    chk("mrst_rfwr", wb_ctrl[1], 0);
    rstn = 1;
    idle(1);
    issue(ADDI1, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_ALU, WB_ALU, 5'd1);
    issue(SW9, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_SW, WB_NW, 5'd9);
    issue(LW8, 0, NPC_PLUS4, EX_IMM, 2'b00, 2'b00, MEM_LW, WB_LW, 5'd8);
    #1 ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      ex_redirect = i == 1;
      #1 chk("frz_hold", pc_hold, 1);
      chk("frz_flush", flush_ifid, 0);
      @(negedge clk);
      chk("frz_ex", ex_ctrl, EX_IMM);
      chk("frz_mem", mem_ctrl, MEM_SW);
      chk("frz_wb", {wb_ctrl, wb_dest}, {WB_ALU, 5'd1});
    end
    ext_stall = 0;
    ex_redirect = 0;
    idle(4);
    issue(ILL, 0, NPC_NOP, EX_ILL, 2'b00, 2'b00, MEM_ALU, WB_NW, 5'd0);
    for (int k = 0; k < 3; k++) begin
      chk("halt_early", halt, 0);
      @(negedge clk);
    end
    chk("halt_set", halt, 1);
    id_instr = ADD988;
    id_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_hold", pc_hold, 1);
      @(negedge clk);
      chk("halt_sticky", halt, 1);
      chk("halt_novalid", ex_ctrl[0], 0);
    end
    id_valid = 0;
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    chk("halt_clear", halt, 0);
    #1 chk("halt_clr_hold", pc_hold, 0);
    idle(4);
    chk("drain", exq.size() + memq.size() + wbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
